serial_addsub_digit: RTL and testbench
======================================

// Module: serial_addsub_digit
// PURPOSE
//  Digit-serial two's-complement adder/subtractor. It is the parametrised successor of the bit-serial adder.
//  Operands arrive LSB digit first, DIGIT_W bits per accepted beat. A word is WORD_DIGITS beats.
//  Per-word add/sub mode; carry, borrow and signed-overflow are reported on the last digit.
//  Placed between serial operand shifters and a result deserialiser in the sequential-arithmetic datapath.
// PARAMETERS
//  DIGIT_W      1  bits per beat (1 = classic bit-serial); legal range >=1
//  WORD_DIGITS  8  beats per word; legal range >=1 (word width = DIGIT_W*WORD_DIGITS)
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        asynchronous, active-low reset
//  in_valid   in   1        beat qualifier; in_a/in_b consumed when 1 (no backpressure)
//  in_a       in   DIGIT_W  operand A digit
//  in_b       in   DIGIT_W  operand B digit
//  in_sub     in   1        1=A-B, 0=A+B; sampled only on first digit of a word
//  in_clear   in   1        synchronous abort: discard partial word
//  out_valid  out  1        result digit qualifier
//  out_digit  out  DIGIT_W  result digit
//  out_last   out  1        out_digit is the word's MS digit
//  out_carry  out  1        carry out of MS digit; valid with out_last (sub: 1=no borrow)
//  out_ovf    out  1        signed overflow of the word; valid with out_last
//  busy       out  1        partial word in progress (dig_cnt != 0)
// BEHAVIOUR
//  - Reset (rst=0, async): dig_cnt=0, carry=0, mode=0, all outputs 0.
//  - State: dig_cnt (0..WORD_DIGITS-1), carry_q, mode_q. No other FSM; dig_cnt==0 is IDLE/FIRST.
//  - Beats are accepted only when in_valid=1. Gaps of any length between beats leave all state frozen.
//  - First beat (dig_cnt==0): eff_sub=in_sub; cin=in_sub. mode_q<=in_sub.
//  - Other beats: eff_sub=mode_q; cin=carry_q.
//  - Per beat: b_eff = eff_sub ? ~in_b : in_b; {c, s} = in_a + b_eff + cin, computed in DIGIT_W+1 bits.
//  - Update: carry_q<=c; dig_cnt<=(dig_cnt==WORD_DIGITS-1) ? 0 : dig_cnt+1.
//  - Latency 1: on the edge after the beat, out_valid=1, out_digit=s, out_last=(dig_cnt was WORD_DIGITS-1).
//  - out_carry/out_ovf: updated only on a last beat.
//    - out_carry=c.
//    - out_ovf=(in_a[MSB]==b_eff[MSB]) && (s[MSB]!=in_a[MSB]).
//    - Otherwise both hold their value.
//  - out_valid=0 on any cycle with no accepted beat. out_digit and out_last hold; out_last is meaningful only with out_valid.
//  - WORD_DIGITS==1: every beat is both first and last. No carry chains between beats.
//  - Back-to-back words: a last beat is immediately followed by a first beat. The new word samples in_sub and uses cin=in_sub. There is no leakage of carry_q.
//  - in_clear=1: dig_cnt<=0, carry_q<=0, mode_q<=0, out_valid<=0.
//    - Takes priority over a simultaneous in_valid; that beat is dropped.
//    - out_carry/out_ovf hold.
//  - Reset mid-word: the partial word is lost. The first valid beat after release is digit 0.
//  - busy=(dig_cnt!=0), driven combinationally from the register.
// STRUCTURE
//  - Package serial_arith_pkg: typedef logic [DIGIT_W-1:0] digit_t is parametric, so it is declared locally.
//    The package holds the clog2-based counter-width helper function and the ADD=1'b0/SUB=1'b1 mode constants.
//  - Sub-module digit_addsub: combinational.
//    Inputs a, b, sub, cin. Outputs s, cout, ovf.
//    Reusable by a future parallel-prefix variant.
//  - Top: counter, carry/mode registers, output registers.
// TESTING (DIGIT_W=4, WORD_DIGITS=2 unless noted; digits listed LSB first)
//  1. ADD 0x7F+0x01: a={F,7}, b={1,0} -> out {0,8}; out_last on 2nd; carry=0, ovf=1.
//  2. SUB 0x05-0x07: a={5,0}, b={7,0}, in_sub=1 -> out {E,F}=0xFE; carry=0 (borrow), ovf=0.
//  3. Back-to-back: 0xFF+0x01 then 0x80-0x01, no idle.
//     Word 1 -> {0,0}, carry=1, ovf=0.
//     Word 2 -> {F,7}, carry=1, ovf=1.
//     Checks that the second word's cin comes from in_sub, not carry_q.
//  4. Gaps and mode sampling: test 1 with in_valid low 3 cycles between digits and in_sub toggled during the gap -> identical result.
//  5. Abort and reset:
//     First digit of 0x12+0x34, then in_clear with in_valid=1 -> no out_valid that cycle, busy=0.
//     Next word 0x11+0x22 -> {3,3}.
//     Repeat with rst asserted mid-word -> outputs 0 immediately.
//  6. DIGIT_W=1, WORD_DIGITS=8: 3+5 -> 8 beats giving 00010000b LSB first; carry=0, ovf=0.
//     Also 127+1 -> ovf=1.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared helpers for the sequential-arithmetic datapath: mode encodings and
// the counter-width helper used by the digit-serial blocks.
package serial_arith_pkg;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/digit_addsub.sv
// One digit of a two's-complement add/subtract: combinational, zero latency.
// Subtraction inverts b; the caller supplies cin=1 on the LS digit.
module digit_addsub #(
    parameter int DIGIT_W = 1
) (
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               sub,
    input  logic               cin,
    output logic [DIGIT_W-1:0] s,
    output logic               cout,
    output logic               ovf
);

    logic [DIGIT_W-1:0] b_eff;
    logic [DIGIT_W:0]   sum;

    assign b_eff = sub ? ~b : b;
    assign sum   = {1'b0, a} + {1'b0, b_eff} + {{DIGIT_W{1'b0}}, cin};
    assign s     = sum[DIGIT_W-1:0];
    assign cout  = sum[DIGIT_W];
    // Only meaningful on the MS digit, where these bits are the word sign bits.
    assign ovf   = (a[DIGIT_W-1] == b_eff[DIGIT_W-1]) && (s[DIGIT_W-1] != a[DIGIT_W-1]);

endmodule

// File: rtl/serial_addsub_digit.sv
// Digit-serial add/sub, LSB digit first; result digit registered one cycle after each beat.
// No backpressure: every in_valid beat is consumed; in_clear aborts a partial word.
module serial_addsub_digit
    import serial_arith_pkg::*;
#(
    parameter int DIGIT_W     = 1,
    parameter int WORD_DIGITS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [DIGIT_W-1:0] in_a,
    input  logic [DIGIT_W-1:0] in_b,
    input  logic               in_sub,
    input  logic               in_clear,
    output logic               out_valid,
    output logic [DIGIT_W-1:0] out_digit,
    output logic               out_last,
    output logic               out_carry,
    output logic               out_ovf,
    output logic               busy
);

    localparam int               CNT_W    = cnt_width(WORD_DIGITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_DIGITS - 1);

    logic [CNT_W-1:0]   dig_cnt;
    logic               carry_q;
    logic               mode_q;
    logic               first_dig;
    logic               last_dig;
    logic               eff_sub;
    logic               cin;
    logic [DIGIT_W-1:0] sum_dig;
    logic               cout;
    logic               ovf;

    assign first_dig = (dig_cnt == '0);
    assign last_dig  = (dig_cnt == LAST_CNT);
    // A new word never inherits carry_q: its carry-in is the subtract "+1".
    assign eff_sub   = first_dig ? in_sub : mode_q;
    assign cin       = first_dig ? in_sub : carry_q;
    assign busy      = !first_dig;

    digit_addsub #(.DIGIT_W(DIGIT_W)) u_digit (
        .a    (in_a),
        .b    (in_b),
        .sub  (eff_sub),
        .cin  (cin),
        .s    (sum_dig),
        .cout (cout),
        .ovf  (ovf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dig_cnt   <= '0;
            carry_q   <= 1'b0;
            mode_q    <= ADD;
            out_valid <= 1'b0;
            out_digit <= '0;
            out_last  <= 1'b0;
            out_carry <= 1'b0;
            out_ovf   <= 1'b0;
        end else if (in_clear) begin
            dig_cnt   <= '0;
            carry_q   <= 1'b0;
            mode_q    <= ADD;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            carry_q   <= cout;
            if (first_dig) begin
                mode_q <= in_sub;
            end
            dig_cnt   <= last_dig ? '0 : dig_cnt + CNT_W'(1);
            out_valid <= 1'b1;
            out_digit <= sum_dig;
            out_last  <= last_dig;
            if (last_dig) begin
                out_carry <= cout;
                out_ovf   <= ovf;
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_addsub_digit.sv
// Directed bench for two configurations (4x2 and 1x8 digits); a word-level
// reference model fills per-digit scoreboards that a negedge monitor drains.
module tb_serial_addsub_digit;

    typedef struct {
        logic [3:0] dig;
        logic       last;
        logic       carry;
        logic       ovf;
    } exp_t;

    logic clk;
    logic rst;

    logic       valid4, sub4, clear4;
    logic [3:0] a4, b4;
    logic       ovalid4, olast4, ocarry4, oovf4, busy4;
    logic [3:0] odig4;

    logic       valid1, sub1, clear1;
    logic [0:0] a1, b1;
    logic       ovalid1, olast1, ocarry1, oovf1, busy1;
    logic [0:0] odig1;

    exp_t q4[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;

    serial_addsub_digit #(.DIGIT_W(4), .WORD_DIGITS(2)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (valid4),
        .in_a      (a4),
        .in_b      (b4),
        .in_sub    (sub4),
        .in_clear  (clear4),
        .out_valid (ovalid4),
        .out_digit (odig4),
        .out_last  (olast4),
        .out_carry (ocarry4),
        .out_ovf   (oovf4),
        .busy      (busy4)
    );

    serial_addsub_digit #(.DIGIT_W(1), .WORD_DIGITS(8)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (valid1),
        .in_a      (a1),
        .in_b      (b1),
        .in_sub    (sub1),
        .in_clear  (clear1),
        .out_valid (ovalid1),
        .out_digit (odig1),
        .out_last  (olast1),
        .out_carry (ocarry1),
        .out_ovf   (oovf1),
        .busy      (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            valid4 = 1'b0;
            valid1 = 1'b0;
        end
    endtask

    // Word-level model: whole 8-bit result computed at once, then sliced into digits.
    task automatic send_word(input bit sel, input logic [7:0] a, input logic [7:0] b,
                             input logic sub, input int gap);
        logic [7:0] be;
        logic [8:0] t;
        logic       ov;
        int         nd;
        exp_t       e;
        be = sub ? ~b : b;
        t  = {1'b0, a} + {1'b0, be} + {8'b0, sub};
        ov = (a[7] == be[7]) && (t[7] != a[7]);
        nd = sel ? 8 : 2;
        for (int d = 0; d < nd; d++) begin
            step();
            if (sel) begin
                valid1 = 1'b1;
                a1     = a[d];
                b1     = b[d];
                sub1   = (d == 0) ? sub : ~sub;
                e.dig  = {3'b0, t[d]};
            end else begin
                valid4 = 1'b1;
                a4     = a[d*4 +: 4];
                b4     = b[d*4 +: 4];
                sub4   = (d == 0) ? sub : ~sub;
                e.dig  = t[d*4 +: 4];
            end
            e.last  = (d == nd - 1);
            e.carry = t[8];
            e.ovf   = ov;
            if (sel) q1.push_back(e);
            else     q4.push_back(e);
            if (d != nd - 1) begin
                for (int g = 0; g < gap; g++) begin
                    step();
                    if (sel) begin
                        valid1 = 1'b0;
                        sub1   = ~sub1;
                    end else begin
                        valid4 = 1'b0;
                        sub4   = ~sub4;
                        a4     = 4'($urandom);
                        b4     = 4'($urandom);
                    end
                end
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && (q4.size() != 0 || q1.size() != 0); i++) idle(1);
        chk("drain4", 16'(q4.size()), 16'd0);
        chk("drain1", 16'(q1.size()), 16'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (ovalid4) begin
            if (q4.size() == 0) begin
                chk("spurious4", 16'd1, 16'd0);
            end else begin
                e = q4.pop_front();
                chk("digit4", 16'(odig4), 16'(e.dig));
                chk("last4", 16'(olast4), 16'(e.last));
                if (e.last) begin
                    chk("carry4", 16'(ocarry4), 16'(e.carry));
                    chk("ovf4", 16'(oovf4), 16'(e.ovf));
                end
            end
        end
        if (ovalid1) begin
            if (q1.size() == 0) begin
                chk("spurious1", 16'd1, 16'd0);
            end else begin
                e = q1.pop_front();
                chk("digit1", {15'b0, odig1}, 16'(e.dig));
                chk("last1", 16'(olast1), 16'(e.last));
                if (e.last) begin
                    chk("carry1", 16'(ocarry1), 16'(e.carry));
                    chk("ovf1", 16'(oovf1), 16'(e.ovf));
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        valid4 = 1'b0; sub4 = 1'b0; clear4 = 1'b0; a4 = '0; b4 = '0;
        valid1 = 1'b0; sub1 = 1'b0; clear1 = 1'b0; a1 = '0; b1 = '0;
        #12;
        chk("rst_valid4", 16'(ovalid4), 16'd0);
        chk("rst_outs4", {11'b0, odig4, ocarry4}, 16'd0);
        chk("rst_flags4", {13'b0, olast4, oovf4, busy4}, 16'd0);
        chk("rst_outs1", {10'b0, ovalid1, odig1, olast1, ocarry1, oovf1, busy1}, 16'd0);
        step();
        rst = 1'b1;

        // Add with signed overflow, then subtract with borrow.
        send_word(0, 8'h7F, 8'h01, 1'b0, 0);
        idle(2);
        send_word(0, 8'h05, 8'h07, 1'b1, 0);
        idle(2);

        // Back-to-back words: the second must not pick up the first's carry.
        send_word(0, 8'hFF, 8'h01, 1'b0, 0);
        send_word(0, 8'h80, 8'h01, 1'b1, 0);
        idle(2);

        // Gaps between digits with in_sub toggling while idle.
        send_word(0, 8'h7F, 8'h01, 1'b0, 3);
        idle(1);
        chk("busy_idle4", 16'(busy4), 16'd0);
        drain();

        // Abort: first digit of 0x12+0x34, then clear together with a valid beat.
        step();
        valid4 = 1'b1; a4 = 4'h2; b4 = 4'h4; sub4 = 1'b0;
        q4.push_back('{dig: 4'h6, last: 1'b0, carry: 1'b0, ovf: 1'b0});
        step();
        chk("busy_mid4", 16'(busy4), 16'd1);
        valid4 = 1'b1; a4 = 4'h1; b4 = 4'h3; clear4 = 1'b1;
        step();
        valid4 = 1'b0; clear4 = 1'b0;
        chk("clear_valid4", 16'(ovalid4), 16'd0);
        chk("clear_busy4", 16'(busy4), 16'd0);
        send_word(0, 8'h11, 8'h22, 1'b0, 0);
        idle(2);

        // Leave carry/ovf set, start a word, then reset mid-word.
        send_word(0, 8'h80, 8'h01, 1'b1, 0);
        idle(2);
        step();
        valid4 = 1'b1; a4 = 4'h5; b4 = 4'h1; sub4 = 1'b0;
        q4.push_back('{dig: 4'h6, last: 1'b0, carry: 1'b0, ovf: 1'b0});
        idle(2);
        chk("busy_pre_rst4", 16'(busy4), 16'd1);
        chk("carry_pre_rst4", {14'b0, ocarry4, oovf4}, 16'h3);
        rst = 1'b0;
        #1;
        chk("rst_mid_outs4", {10'b0, ovalid4, odig4, olast4}, 16'd0);
        chk("rst_mid_flags4", {13'b0, ocarry4, oovf4, busy4}, 16'd0);
        step();
        rst = 1'b1;
        send_word(0, 8'h11, 8'h22, 1'b0, 0);
        idle(2);

        // Bit-serial configuration.
        send_word(1, 8'd3, 8'd5, 1'b0, 0);
        send_word(1, 8'd127, 8'd1, 1'b0, 0);
        idle(2);
        send_word(1, 8'h05, 8'h07, 1'b1, 2);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
